// File: rtl/evtstamp.sv
// evtstamp - CSR-bus event timestamper.
//
// Timestamps edges on two asynchronous event inputs against a free-running
// 30-bit system-clock counter and queues the event words in a FIFO that the
// CPU drains over the CSR bus. Event word layout: {ch, pol, ts[29:0]}.
//
// Build option:
//   EVTSTAMP_FALLING_EN  defined     -> falling edges are captured too (pol=1)
//                        not defined -> only rising edges, pol is always 0
//
// Parameters:
//   csr_addr        CSR page, selected when csr_a[13:10] == csr_addr
//   fifo_depth_log2 FIFO holds 2**fifo_depth_log2 words
//
// Ports:
//   sys_clk  system clock
//   sys_rst  synchronous active-high reset
//   csr_a    CSR address, csr_a[2:0] selects the register
//   csr_we   CSR write strobe
//   csr_di   CSR write data
//   csr_do   registered CSR read data, 0 when the page is not selected
//   evt_i    asynchronous event inputs
//   irq      level interrupt, irq_en & FIFO not empty (registered)
//
// Registers: 0 CTRL, 1 STATUS, 2 DATA, 3 POP, 4 TIME, 5-7 read as 0.

module evtstamp #(
    parameter logic [3:0] csr_addr        = 4'h2,
    parameter int         fifo_depth_log2 = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    input  logic [1:0]  evt_i,
    output logic        irq
);

    localparam int DEPTH = 1 << fifo_depth_log2;
    localparam int AW    = fifo_depth_log2;
    localparam int LW    = fifo_depth_log2 + 1;

    logic [1:0]    sync1, sync2, prev;
    logic [1:0]    edge_det, edge_pol;
    logic [29:0]   ts;
    logic [1:0]    en;
    logic          irq_en;
    logic          ovf;
    logic [1:0]    pend_v;
    logic [31:0]   pend_w [2];
    logic [31:0]   mem [DEPTH];
    logic [LW-1:0] wptr, rptr, level;
    logic          empty, full;
    logic [2:0]    reg_sel;
    logic          sel, wr, flush, ovf_clr, pop;
    logic          push_req, push_ok, push_drop;
    logic [31:0]   push_word;
    logic [1:0]    slot_done, cap, edge_ovf;
    logic [31:0]   head, rdata, status;
    logic          unused_bits;

    // Two-flop synchronizer plus one history flop for edge detection. All
    // reset to 0, so an input already high after reset shows up as a rise.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= evt_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

`ifdef EVTSTAMP_FALLING_EN
    assign edge_det = sync2 ^ prev;
    assign edge_pol = prev & ~sync2;
`else
    assign edge_det = sync2 & ~prev;
    assign edge_pol = 2'b00;
`endif

    assign reg_sel = csr_a[2:0];
    assign sel     = (csr_a[13:10] == csr_addr);
    assign wr      = sel & csr_we;
    assign flush   = wr && (reg_sel == 3'd0) && csr_di[8];
    assign ovf_clr = wr && (reg_sel == 3'd1) && csr_di[10];

    assign level = wptr - rptr;
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign pop   = wr && (reg_sel == 3'd3) && !empty;
    assign head  = empty ? '0 : mem[rptr[AW-1:0]];

    // Channel 0 wins the single push port; channel 1 waits a cycle. A full
    // FIFO still accepts a push when a pop frees a word in the same cycle.
    assign push_req     = |pend_v;
    assign push_word    = pend_v[0] ? pend_w[0] : pend_w[1];
    assign push_ok      = push_req & (~full | pop);
    assign push_drop    = push_req & full & ~pop;
    assign slot_done[0] = pend_v[0];
    assign slot_done[1] = pend_v[1] & ~pend_v[0];

    // Edges on a disabled channel are invisible; edges on a busy slot are lost.
    assign cap      = edge_det & en & ~pend_v;
    assign edge_ovf = edge_det & en & pend_v;

    // Pending slots leave when pushed or dropped; flush discards everything.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            pend_v <= '0;
        end else begin
            pend_v <= (pend_v & ~slot_done) | cap;
        end
    end

    always_ff @(posedge sys_clk) begin
        for (int c = 0; c < 2; c++) begin
            if (cap[c]) begin
                pend_w[c] <= {1'(c), edge_pol[c], ts};
            end
        end
    end

    // FIFO pointers carry one extra bit so full and empty are distinct.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + LW'(1);
            end
            if (pop) begin
                rptr <= rptr + LW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok && !flush) begin
            mem[wptr[AW-1:0]] <= push_word;
        end
    end

    always_comb begin
        status         = '0;
        status[LW-1:0] = level;
        status[8]      = empty;
        status[9]      = full;
        status[10]     = ovf;
        rdata          = '0;
        case (reg_sel)
            3'd0:    rdata = {29'd0, irq_en, en};
            3'd1:    rdata = status;
            3'd2:    rdata = head;
            3'd4:    rdata = {2'b00, ts};
            default: rdata = '0;
        endcase
    end

    // Control, sticky overflow (a new overflow beats a clear), timebase and
    // the registered bus outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ts     <= '0;
            en     <= '0;
            irq_en <= 1'b0;
            ovf    <= 1'b0;
            irq    <= 1'b0;
            csr_do <= '0;
        end else begin
            ts <= ts + 30'd1;
            if (wr && (reg_sel == 3'd0)) begin
                en     <= csr_di[1:0];
                irq_en <= csr_di[2];
            end
            ovf    <= (ovf & ~ovf_clr) | (~flush & (push_drop | (|edge_ovf)));
            irq    <= irq_en & ~empty;
            csr_do <= sel ? rdata : '0;
        end
    end

    assign unused_bits = ^{csr_a[9:3], csr_di[31:11], csr_di[9], csr_di[7:3]};

endmodule

// File: tb/tb_evtstamp.sv
// tb_evtstamp - self-checking bench for evtstamp.
//
// Expected event words come from a timeline model: the bench knows the
// timebase value of the cycle in which it changes an input, and every
// recorded edge carries that value plus the two-cycle synchronizer offset.
// Words are expected in the order the edges were applied (ch0 before ch1
// within a cycle). Build with EVTSTAMP_FALLING_EN to expect falling words.

module tb_evtstamp;

`ifdef EVTSTAMP_FALLING_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    localparam logic [2:0] R_CTRL   = 3'd0;
    localparam logic [2:0] R_STATUS = 3'd1;
    localparam logic [2:0] R_DATA   = 3'd2;
    localparam logic [2:0] R_POP    = 3'd3;
    localparam logic [2:0] R_TIME   = 3'd4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic [1:0]  evt_i;
    logic        irq;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          base_cyc = 0;
    logic [29:0] base_val = '0;
    logic [31:0] exp_q[$];

    evtstamp #(.csr_addr(4'h2), .fifo_depth_log2(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_di  (csr_di),
        .csr_do  (csr_do),
        .evt_i   (evt_i),
        .irq     (irq)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Timebase value during the current cycle, per the counter's definition.
    function automatic logic [29:0] model_ts();
        return base_val + 30'(cyc - base_cyc);
    endfunction

    task automatic csr_read(input logic [2:0] off, output logic [31:0] d, output logic [29:0] t_at);
        @(negedge sys_clk);
        csr_a  = {4'h2, 7'd0, off};
        csr_we = 1'b0;
        t_at   = model_ts();
        @(negedge sys_clk);
        d = csr_do;
    endtask

    task automatic csr_write(input logic [2:0] off, input logic [31:0] data);
        @(negedge sys_clk);
        csr_a  = {4'h2, 7'd0, off};
        csr_we = 1'b1;
        csr_di = data;
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_di = '0;
    endtask

    // One pulse on one channel; the edges the DUT should record go to exp_q.
    task automatic pulse_ch(input bit ch, input int hi, input int lo);
        logic [29:0] t;
        @(negedge sys_clk);
        t = model_ts();
        evt_i[ch] = 1'b1;
        exp_q.push_back({ch, 1'b0, 30'(t + 30'd2)});
        repeat (hi) @(negedge sys_clk);
        t = model_ts();
        evt_i[ch] = 1'b0;
        if (FALL_EN) exp_q.push_back({ch, 1'b1, 30'(t + 30'd2)});
        repeat (lo) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [29:0] t1, t2, tx;
        logic [31:0] time1;
        sys_rst = 1'b1;
        evt_i   = 2'b00;
        csr_a   = '0;
        csr_we  = 1'b0;
        csr_di  = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst  = 1'b0;
        base_cyc = cyc;
        base_val = '0;
        csr_read(R_CTRL, d, tx);
        checks++;
        if (d !== 32'h0) begin fails++; $display("[TB] FAIL reset_ctrl: got 0x%08h, expected 0x%08h", d, 32'h0); end
        csr_read(R_STATUS, d, tx);
        checks++;
        if (d !== 32'h100) begin fails++; $display("[TB] FAIL reset_status: got 0x%08h, expected 0x%08h", d, 32'h100); end
        csr_read(R_DATA, d, tx);
        checks++;
        if (d !== 32'h0) begin fails++; $display("[TB] FAIL reset_data: got 0x%08h, expected 0x%08h", d, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin fails++; $display("[TB] FAIL reset_irq: got %b, expected 0", irq); end
        csr_read(R_TIME, d, t1);
        time1 = d;
        checks++;
        if (d !== {2'b00, t1}) begin fails++; $display("[TB] FAIL reset_time1: got 0x%08h, expected 0x%08h", d, {2'b00, t1}); end
        csr_read(R_TIME, d, t2);
        checks++;
        if (d !== {2'b00, t2}) begin fails++; $display("[TB] FAIL reset_time2: got 0x%08h, expected 0x%08h", d, {2'b00, t2}); end
        checks++;
        if (!(d > time1)) begin fails++; $display("[TB] FAIL time_increases: got 0x%08h, expected above 0x%08h", d, time1); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic [29:0] tx;
        int guard;
        csr_write(R_CTRL, 32'h5);
        guard = 0;
        while (model_ts() != 30'd100 && guard < 200) begin
            @(negedge sys_clk);
            guard++;
        end
        evt_i[0] = 1'b1;
        repeat (4) @(negedge sys_clk);
        csr_read(R_DATA, d, tx);
        checks++;
        if (d !== 32'h66) begin fails++; $display("[TB] FAIL single_data: got 0x%08h, expected 0x%08h", d, 32'h66); end
        csr_read(R_STATUS, d, tx);
        checks++;
        if (d !== 32'h1) begin fails++; $display("[TB] FAIL single_level: got 0x%08h, expected 0x%08h", d, 32'h1); end
        checks++;
        if (irq !== 1'b1) begin fails++; $display("[TB] FAIL single_irq: got %b, expected 1", irq); end
        csr_write(R_POP, 32'h0);
        csr_read(R_STATUS, d, tx);
        checks++;
        if (d !== 32'h100) begin fails++; $display("[TB] FAIL single_pop_status: got 0x%08h, expected 0x%08h", d, 32'h100); end
        checks++;
        if (irq !== 1'b0) begin fails++; $display("[TB] FAIL single_pop_irq: got %b, expected 0", irq); end
        // Falling edge and a new pulse while disabled must leave no trace.
        csr_write(R_CTRL, 32'h4);
        evt_i[0] = 1'b0;
        repeat (3) @(negedge sys_clk);
        evt_i[0] = 1'b1;
        repeat (3) @(negedge sys_clk);
        evt_i[0] = 1'b0;
        repeat (4) @(negedge sys_clk);
        csr_read(R_STATUS, d, tx);
        checks++;
        if (d !== 32'h100) begin fails++; $display("[TB] FAIL disabled_ignored: got 0x%08h, expected 0x%08h", d, 32'h100); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        logic [29:0] t, tx;
        csr_write(R_CTRL, 32'h3);
        @(negedge sys_clk);
        t = model_ts();
        evt_i = 2'b11;
        repeat (5) @(negedge sys_clk);
        csr_read(R_STATUS, d, tx);
        checks++;
        if (d !== 32'h2) begin fails++; $display("[TB] FAIL simul_level: got 0x%08h, expected 0x%08h", d, 32'h2); end
        csr_read(R_DATA, d, tx);
        checks++;
        if (d !== {2'b00, 30'(t + 30'd2)}) begin fails++; $display("[TB] FAIL simul_ch0: got 0x%08h, expected 0x%08h", d, {2'b00, 30'(t + 30'd2)}); end
        csr_write(R_POP, 32'h0);
        csr_read(R_DATA, d, tx);
        checks++;
        if (d !== {2'b10, 30'(t + 30'd2)}) begin fails++; $display("[TB] FAIL simul_ch1: got 0x%08h, expected 0x%08h", d, {2'b10, 30'(t + 30'd2)}); end
        csr_write(R_POP, 32'h0);
        csr_write(R_CTRL, 32'h0);
        evt_i = 2'b00;
        repeat (4) @(negedge sys_clk);
        csr_read(R_STATUS, d, tx);
        checks++;
        if (d !== 32'h100) begin fails++; $display("[TB] FAIL simul_drained: got 0x%08h, expected 0x%08h", d, 32'h100); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        logic [29:0] tx;
        exp_q.delete();
        csr_write(R_CTRL, 32'h1);
        for (int k = 0; k < 17; k++) pulse_ch(1'b0, 2, 2);
        repeat (3) @(negedge sys_clk);
        while (exp_q.size() > 16) void'(exp_q.pop_back());
        csr_read(R_STATUS, d, tx);
        checks++;
        if (d !== 32'h610) begin fails++; $display("[TB] FAIL ovf_status: got 0x%08h, expected 0x%08h", d, 32'h610); end
        csr_write(R_STATUS, 32'h400);
        csr_read(R_STATUS, d, tx);
        checks++;
        if (d !== 32'h210) begin fails++; $display("[TB] FAIL ovf_clear: got 0x%08h, expected 0x%08h", d, 32'h210); end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            csr_read(R_DATA, d, tx);
            checks++;
            if (d !== e) begin fails++; $display("[TB] FAIL ovf_word%0d: got 0x%08h, expected 0x%08h", i, d, e); end
            csr_write(R_POP, 32'h0);
        end
        csr_write(R_CTRL, 32'h0);
        csr_read(R_STATUS, d, tx);
        checks++;
        if (d !== 32'h100) begin fails++; $display("[TB] FAIL ovf_drained: got 0x%08h, expected 0x%08h", d, 32'h100); end
    endtask

    task automatic test_wrap_flush();
        logic [31:0] d, e;
        logic [29:0] t;
        exp_q.delete();
        csr_write(R_CTRL, 32'h3);
        @(negedge sys_clk);
        force dut.ts = 30'h3FFF_FFF8;
        #1;
        release dut.ts;
        base_cyc = cyc;
        base_val = 30'h3FFF_FFF8;
        csr_read(R_TIME, d, t);
        checks++;
        if (d !== {2'b00, t}) begin fails++; $display("[TB] FAIL wrap_time: got 0x%08h, expected 0x%08h", d, {2'b00, t}); end
        for (int i = 0; i < 4; i++) pulse_ch(1'(i), 2, 2);
        repeat (3) @(negedge sys_clk);
        csr_read(R_STATUS, d, t);
        checks++;
        if (d !== 32'(exp_q.size())) begin fails++; $display("[TB] FAIL wrap_level: got 0x%08h, expected 0x%08h", d, 32'(exp_q.size())); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr_read(R_DATA, d, t);
            checks++;
            if (d !== e) begin fails++; $display("[TB] FAIL wrap_word: got 0x%08h, expected 0x%08h", d, e); end
            csr_write(R_POP, 32'h0);
        end
        pulse_ch(1'b0, 2, 2);
        pulse_ch(1'b1, 2, 4);
        exp_q.delete();
        csr_write(R_CTRL, 32'h103);
        csr_read(R_STATUS, d, t);
        checks++;
        if (d !== 32'h100) begin fails++; $display("[TB] FAIL flush_status: got 0x%08h, expected 0x%08h", d, 32'h100); end
        csr_read(R_CTRL, d, t);
        checks++;
        if (d !== 32'h3) begin fails++; $display("[TB] FAIL flush_ctrl: got 0x%08h, expected 0x%08h", d, 32'h3); end
        pulse_ch(1'b1, 3, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr_read(R_DATA, d, t);
            checks++;
            if (d !== e) begin fails++; $display("[TB] FAIL post_flush_word: got 0x%08h, expected 0x%08h", d, e); end
            csr_write(R_POP, 32'h0);
        end
        csr_write(R_CTRL, 32'h0);
    endtask

    task automatic test_falling();
        logic [31:0] d, e;
        logic [29:0] t;
        exp_q.delete();
        csr_write(R_CTRL, 32'h1);
        pulse_ch(1'b0, 5, 5);
        csr_read(R_STATUS, d, t);
        checks++;
        if (d !== (FALL_EN ? 32'h2 : 32'h1)) begin fails++; $display("[TB] FAIL fall_level: got 0x%08h, expected 0x%08h", d, FALL_EN ? 32'h2 : 32'h1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr_read(R_DATA, d, t);
            checks++;
            if (d !== e) begin fails++; $display("[TB] FAIL fall_word: got 0x%08h, expected 0x%08h", d, e); end
            csr_write(R_POP, 32'h0);
        end
        csr_write(R_CTRL, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic [29:0] t;
        logic [1:0]  lvl;
        int          cnt[2];
        int          k;
        csr_write(R_CTRL, 32'h7);
        for (int round = 0; round < 3; round++) begin
            exp_q.delete();
            lvl = 2'b00;
            for (int c = 0; c < 2; c++) cnt[c] = $urandom_range(8, 3);
            k = 0;
            while ((k < 20 || lvl != 2'b00) && k < 60) begin
                @(negedge sys_clk);
                t = model_ts();
                for (int c = 0; c < 2; c++) begin
                    if (cnt[c] > 0) begin
                        cnt[c]--;
                    end else if (k < 20 || lvl[c]) begin
                        lvl[c] = ~lvl[c];
                        if (lvl[c] || FALL_EN) exp_q.push_back({1'(c), ~lvl[c], 30'(t + 30'd2)});
                        cnt[c] = $urandom_range(8, 3);
                    end
                end
                evt_i = lvl;
                k++;
            end
            repeat (4) @(negedge sys_clk);
            csr_read(R_STATUS, d, t);
            e = (exp_q.size() == 0) ? 32'h100 : 32'(exp_q.size());
            checks++;
            if (d !== e) begin fails++; $display("[TB] FAIL rand_level r%0d: got 0x%08h, expected 0x%08h", round, d, e); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                csr_read(R_DATA, d, t);
                checks++;
                if (d !== e) begin fails++; $display("[TB] FAIL rand_word r%0d: got 0x%08h, expected 0x%08h", round, d, e); end
                csr_write(R_POP, 32'h0);
            end
            csr_read(R_STATUS, d, t);
            checks++;
            if (d !== 32'h100) begin fails++; $display("[TB] FAIL rand_drained r%0d: got 0x%08h, expected 0x%08h", round, d, 32'h100); end
            checks++;
            if (irq !== 1'b0) begin fails++; $display("[TB] FAIL rand_irq r%0d: got %b, expected 0", round, irq); end
        end
        csr_write(R_CTRL, 32'h0);
    endtask

    // Main sequence.
    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_overflow();
        test_falling();
        test_wrap_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Guards against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
